// File: rtl/planemem_if.sv
// Host-write and PWM-read signal bundle for planemem.
// The master side is the host/PWM engine; the slave side is the memory.
interface planemem_if #(
  parameter int PWM_WIDTH = 16,
  parameter int NUM_PWM   = 4
);
  localparam int AW = $clog2(PWM_WIDTH);

  logic               write_enable;
  logic [AW-1:0]      waddr;
  logic [NUM_PWM-1:0] wdata;
  logic [NUM_PWM-1:0] wmask;
  logic               commit;
  logic               wready;
  logic               latch_mem;
  logic [AW-1:0]      raddr;
  logic [NUM_PWM-1:0] rdata;
  logic               pending;
  logic               swapped;
  logic               frame_drop;
  logic               err;

  modport master (
    output write_enable, waddr, wdata, wmask, commit, latch_mem, raddr,
    input  wready, rdata, pending, swapped, frame_drop, err
  );

  modport slave (
    input  write_enable, waddr, wdata, wmask, commit, latch_mem, raddr,
    output wready, rdata, pending, swapped, frame_drop, err
  );
endinterface

// File: rtl/planemem.sv
// Multi-bank bit-plane memory for the PWM/BCM path: commit/latch frame buffering
// (double or triple) plus a copy engine that carries the committed frame forward.
module planemem #(
  parameter int PWM_WIDTH = 16,
  parameter int NUM_PWM   = 4,
  parameter int NUM_BANKS = 3
) (
  input logic       clk,
  input logic       rst,
  planemem_if.slave bus
);
  // state  | meaning
  // IDLE   | writer owns the write bank, wready=1
  // COPY   | copying src bank into the write bank, one plane per cycle
  localparam int AW     = $clog2(PWM_WIDTH);
  localparam int PW     = $clog2(NUM_BANKS);
  localparam bit TRIPLE = (NUM_BANKS == 3);

  if (NUM_BANKS != 2 && NUM_BANKS != 3) begin : g_bad_banks
    $error("planemem: NUM_BANKS must be 2 or 3");
  end

  typedef enum logic {S_IDLE, S_COPY} state_t;

  state_t             r_state, w_state_nx;
  logic [NUM_PWM-1:0] r_mem [NUM_BANKS][PWM_WIDTH];
  logic [PW-1:0]      r_rd, r_wr, r_rdy, r_src;
  logic [AW-1:0]      r_k;
  logic [NUM_PWM-1:0] r_rdata;
  logic               r_pending, r_swapped, r_drop, r_err;
  logic               w_wready, w_waddr_ok, w_wr_acc, w_c, w_l, w_start, w_copy_last;

  assign w_wready    = (r_state == S_IDLE);
  assign w_waddr_ok  = ({1'b0, bus.waddr} < (AW+1)'(PWM_WIDTH));
  assign w_wr_acc    = bus.write_enable & w_wready & w_waddr_ok;
  assign w_c         = bus.commit & w_wready;
  assign w_l         = bus.latch_mem & r_pending;
  // Triple mode refreshes the write bank on commit; double mode only after the swap.
  assign w_start     = TRIPLE ? w_c : w_l;
  assign w_copy_last = (r_k == AW'(PWM_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nx = S_COPY;
      S_COPY:  if (w_copy_last) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_k <= '0;
    else if (w_start)           r_k <= '0;
    else if (r_state == S_COPY) r_k <= r_k + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd      <= PW'(0);
      r_wr      <= PW'(1);
      r_rdy     <= PW'(2);
      r_src     <= PW'(0);
      r_pending <= 1'b0;
      r_swapped <= 1'b0;
      r_drop    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_swapped <= w_l;
      r_drop    <= TRIPLE & w_c & ~w_l & r_pending;
      if ((bus.write_enable | bus.commit) & ~w_wready) r_err <= 1'b1;
      if (TRIPLE) begin
        if (w_l && w_c) begin
          r_rd      <= r_rdy;
          r_rdy     <= r_wr;
          r_wr      <= r_rd;
          r_pending <= 1'b1;
        end else if (w_l) begin
          r_rd      <= r_rdy;
          r_rdy     <= r_rd;
          r_pending <= 1'b0;
        end else if (w_c) begin
          r_rdy     <= r_wr;
          r_wr      <= r_rdy;
          r_pending <= 1'b1;
        end
        if (w_c) r_src <= r_wr;
      end else begin
        // A commit while a frame is queued changes nothing.
        if (w_l) begin
          r_rd      <= r_wr;
          r_wr      <= r_rd;
          r_src     <= r_wr;
          r_pending <= 1'b0;
        end else if (w_c) begin
          r_pending <= 1'b1;
        end
      end
    end
  end

  // Storage is deliberately not reset; host writes and copies never coincide.
  always_ff @(posedge clk) begin
    if (r_state == S_COPY) begin
      r_mem[r_wr][r_k] <= r_mem[r_src][r_k];
    end else if (w_wr_acc) begin
      for (int i = 0; i < NUM_PWM; i++) begin
        if (bus.wmask[i]) r_mem[r_wr][bus.waddr][i] <= bus.wdata[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= r_mem[r_rd][bus.raddr];
  end

  assign bus.wready     = w_wready;
  assign bus.rdata      = r_rdata;
  assign bus.pending    = r_pending;
  assign bus.swapped    = r_swapped;
  assign bus.frame_drop = r_drop;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_planemem.sv
// Bench for planemem: a triple-buffered (16x4) and a double-buffered (8x4) instance
// checked every cycle against a frame-level model, plus literal spot checks.
module tb_planemem;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: triple instance, index 1: double instance
  logic       t_rst[2];
  logic       t_we[2], t_commit[2], t_latch[2];
  logic [3:0] t_waddr[2], t_wdata[2], t_wmask[2], t_raddr[2];
  logic [3:0] d_rdata[2];
  logic       d_wready[2], d_pending[2], d_swapped[2], d_drop[2], d_err[2];

  planemem_if #(.PWM_WIDTH(16), .NUM_PWM(4)) if3 ();
  planemem_if #(.PWM_WIDTH(8),  .NUM_PWM(4)) if2 ();

  assign if3.write_enable = t_we[0];
  assign if3.waddr        = t_waddr[0];
  assign if3.wdata        = t_wdata[0];
  assign if3.wmask        = t_wmask[0];
  assign if3.commit       = t_commit[0];
  assign if3.latch_mem    = t_latch[0];
  assign if3.raddr        = t_raddr[0];
  assign d_rdata[0]   = if3.rdata;
  assign d_wready[0]  = if3.wready;
  assign d_pending[0] = if3.pending;
  assign d_swapped[0] = if3.swapped;
  assign d_drop[0]    = if3.frame_drop;
  assign d_err[0]     = if3.err;

  assign if2.write_enable = t_we[1];
  assign if2.waddr        = t_waddr[1][2:0];
  assign if2.wdata        = t_wdata[1];
  assign if2.wmask        = t_wmask[1];
  assign if2.commit       = t_commit[1];
  assign if2.latch_mem    = t_latch[1];
  assign if2.raddr        = t_raddr[1][2:0];
  assign d_rdata[1]   = if2.rdata;
  assign d_wready[1]  = if2.wready;
  assign d_pending[1] = if2.pending;
  assign d_swapped[1] = if2.swapped;
  assign d_drop[1]    = if2.frame_drop;
  assign d_err[1]     = if2.err;

  planemem #(.PWM_WIDTH(16), .NUM_PWM(4), .NUM_BANKS(3)) dut3 (
    .clk(clk), .rst(t_rst[0]), .bus(if3.slave));
  planemem #(.PWM_WIDTH(8), .NUM_PWM(4), .NUM_BANKS(2)) dut2 (
    .clk(clk), .rst(t_rst[1]), .bus(if2.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(string nm, int u, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[u%0d] @%0t: got %0d, expected %0d", nm, u, $time, act, exp);
    end
  endtask

  // Frame-level model: contents of the displayed, queued and host-side frames
  // (-1 = unknown plane); bank identities are not modelled.
  int m_rd[2][16], m_rdy[2][16], m_wr[2][16];
  bit m_pend[2], m_err[2], m_swp[2], m_drop[2];
  int m_busy[2], m_rdata[2];

  task automatic model_step(int u);
    int n, a;
    bit ok, c, l;
    logic [3:0] ov, mk;
    n = (u == 0) ? 16 : 8;
    if (t_rst[u]) begin
      for (int p = 0; p < 16; p++) begin
        m_rd[u][p] = -1; m_rdy[u][p] = -1; m_wr[u][p] = -1;
      end
      m_pend[u] = 0; m_err[u] = 0; m_swp[u] = 0; m_drop[u] = 0;
      m_busy[u] = 0; m_rdata[u] = 0;
    end else begin
      ok = (m_busy[u] == 0);
      m_rdata[u] = m_rd[u][int'(t_raddr[u]) % n];
      if (!ok) m_busy[u]--;
      if ((t_we[u] || t_commit[u]) && !ok) m_err[u] = 1;
      if (t_we[u] && ok) begin
        a  = int'(t_waddr[u]) % n;
        mk = t_wmask[u];
        if (mk == 4'hF) m_wr[u][a] = int'(t_wdata[u]);
        else if (mk != 4'h0 && m_wr[u][a] >= 0) begin
          ov = m_wr[u][a][3:0];
          m_wr[u][a] = int'((ov & ~mk) | (t_wdata[u] & mk));
        end else if (mk != 4'h0) m_wr[u][a] = -1;
      end
      c = t_commit[u] && ok;
      l = t_latch[u] && m_pend[u];
      m_swp[u]  = l;
      m_drop[u] = 0;
      if (u == 0) begin
        if (l) for (int p = 0; p < n; p++) m_rd[u][p] = m_rdy[u][p];
        if (c) begin
          if (m_pend[u] && !l) m_drop[u] = 1;
          for (int p = 0; p < n; p++) m_rdy[u][p] = m_wr[u][p];
          m_busy[u] = n;
          m_pend[u] = 1;
        end else if (l) m_pend[u] = 0;
      end else begin
        if (l) begin
          for (int p = 0; p < n; p++) m_rd[u][p] = m_wr[u][p];
          m_pend[u] = 0;
          m_busy[u] = n;
        end else if (c) m_pend[u] = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) model_step(u);
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!t_rst[u]) begin
        if (m_rdata[u] >= 0) chk("rdata", u, int'(d_rdata[u]), m_rdata[u]);
        chk("wready",     u, int'(d_wready[u]),  int'(m_busy[u] == 0));
        chk("pending",    u, int'(d_pending[u]), int'(m_pend[u]));
        chk("swapped",    u, int'(d_swapped[u]), int'(m_swp[u]));
        chk("frame_drop", u, int'(d_drop[u]),    int'(m_drop[u]));
        chk("err",        u, int'(d_err[u]),     int'(m_err[u]));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(int u, int a, int d, int m);
    t_we[u] = 1'b1; t_waddr[u] = 4'(a); t_wdata[u] = 4'(d); t_wmask[u] = 4'(m);
    cyc();
    t_we[u] = 1'b0;
  endtask

  task automatic do_commit(int u);
    t_commit[u] = 1'b1; cyc(); t_commit[u] = 1'b0;
  endtask

  task automatic do_latch(int u);
    t_latch[u] = 1'b1; cyc(); t_latch[u] = 1'b0;
  endtask

  task automatic wait_ready(int u);
    int k = 0;
    while (!d_wready[u] && k < 100) begin cyc(); k++; end
    if (!d_wready[u]) chk("wready_timeout", u, int'(d_wready[u]), 1);
  endtask

  task automatic rd_chk(string nm, int u, int a, int exp);
    t_raddr[u] = 4'(a);
    cyc();
    chk(nm, u, int'(d_rdata[u]), exp);
  endtask

  initial begin
    int t0, k;
    for (int u = 0; u < 2; u++) begin
      t_rst[u] = 1'b1; t_we[u] = 1'b0; t_commit[u] = 1'b0; t_latch[u] = 1'b0;
      t_waddr[u] = '0; t_wdata[u] = '0; t_wmask[u] = '0; t_raddr[u] = '0;
    end
    repeat (3) cyc();
    t_rst[0] = 1'b0; t_rst[1] = 1'b0;
    cyc();
    for (int u = 0; u < 2; u++) begin
      chk("reset_rdata",   u, int'(d_rdata[u]),   0);
      chk("reset_wready",  u, int'(d_wready[u]),  1);
      chk("reset_pending", u, int'(d_pending[u]), 0);
      chk("reset_err",     u, int'(d_err[u]),     0);
    end

    // Triple: full frame of plane indices, commit, latch.
    for (int p = 0; p < 16; p++) wr(0, p, p, 'hF);
    do_commit(0);
    chk("t_pending_after_commit", 0, int'(d_pending[0]), 1);
    do_latch(0);
    chk("t_swapped_pulse", 0, int'(d_swapped[0]), 1);
    cyc();
    chk("t_swapped_single", 0, int'(d_swapped[0]), 0);
    for (int p = 0; p < 16; p++) rd_chk("t_frame0", 0, p, p);

    // Masked partial update of plane 3 on top of the carried-forward frame.
    wait_ready(0);
    rd_chk("t_p3_old", 0, 3, 3);
    wr(0, 3, 'hA, 'h1);
    do_commit(0);
    rd_chk("t_p3_before_latch", 0, 3, 3);
    do_latch(0);
    rd_chk("t_p3_after_latch", 0, 3, 2);
    rd_chk("t_p4_unchanged", 0, 4, 4);

    // Two commits without a latch: first frame dropped.
    wait_ready(0);
    wr(0, 0, 5, 'hF);
    do_commit(0);
    wait_ready(0);
    wr(0, 0, 9, 'hF);
    do_commit(0);
    chk("t_frame_drop", 0, int'(d_drop[0]), 1);
    do_latch(0);
    chk("t_drop_single", 0, int'(d_drop[0]), 0);
    rd_chk("t_frame_b", 0, 0, 9);
    chk("t_pending_cleared", 0, int'(d_pending[0]), 0);

    // Latch and commit in the same cycle with a frame pending.
    wait_ready(0);
    wr(0, 1, 7, 'hF);
    do_commit(0);
    wait_ready(0);
    wr(0, 1, 'hC, 'hF);
    t_latch[0] = 1'b1; t_commit[0] = 1'b1;
    cyc();
    t_latch[0] = 1'b0; t_commit[0] = 1'b0;
    chk("t_lc_pending", 0, int'(d_pending[0]), 1);
    chk("t_lc_no_drop", 0, int'(d_drop[0]), 0);
    rd_chk("t_lc_read_old_pending", 0, 1, 7);
    wait_ready(0);
    do_latch(0);
    rd_chk("t_lc_next_frame", 0, 1, 'hC);
    rd_chk("t_lc_p2", 0, 2, 2);

    // Busy violation: write two cycles after a commit.
    wait_ready(0);
    do_commit(0);
    t0 = cyc_n;
    cyc();
    wr(0, 5, 0, 'hF);
    chk("t_err_set", 0, int'(d_err[0]), 1);
    k = 0;
    while (!d_wready[0] && k < 100) begin cyc(); k++; end
    chk("t_wready_latency", 0, cyc_n - t0, 16);
    do_latch(0);
    rd_chk("t_write_ignored", 0, 5, 5);
    chk("t_err_sticky", 0, int'(d_err[0]), 1);

    // Double: latch with nothing pending.
    do_latch(1);
    chk("d_no_swap", 1, int'(d_swapped[1]), 0);
    chk("d_no_pending", 1, int'(d_pending[1]), 0);
    for (int p = 0; p < 8; p++) wr(1, p, 15 - p, 'hF);
    do_commit(1);
    chk("d_pending", 1, int'(d_pending[1]), 1);
    chk("d_wready_after_commit", 1, int'(d_wready[1]), 1);
    do_latch(1);
    t0 = cyc_n;
    chk("d_swapped", 1, int'(d_swapped[1]), 1);
    chk("d_busy", 1, int'(d_wready[1]), 0);
    k = 0;
    while (!d_wready[1] && k < 100) begin cyc(); k++; end
    chk("d_wready_latency", 1, cyc_n - t0, 8);
    for (int p = 0; p < 8; p++) rd_chk("d_frame", 1, p, 15 - p);

    // Double: reset in the middle of a copy.
    wr(1, 0, 3, 'hF);
    do_commit(1);
    t_raddr[1] = 4'd0;
    do_latch(1);
    cyc();
    wr(1, 2, 1, 'hF);
    chk("d_err_set", 1, int'(d_err[1]), 1);
    chk("d_new_frame", 1, int'(d_rdata[1]), 3);
    #2 t_rst[1] = 1'b1;
    #1;
    chk("d_arst_rdata",   1, int'(d_rdata[1]),   0);
    chk("d_arst_wready",  1, int'(d_wready[1]),  1);
    chk("d_arst_pending", 1, int'(d_pending[1]), 0);
    chk("d_arst_swapped", 1, int'(d_swapped[1]), 0);
    chk("d_arst_drop",    1, int'(d_drop[1]),    0);
    chk("d_arst_err",     1, int'(d_err[1]),     0);
    cyc();
    cyc();
    t_rst[1] = 1'b0;
    cyc();
    chk("d_post_reset_wready", 1, int'(d_wready[1]), 1);
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/planemem.md
# planemem

Parametrised multi-bank bit-plane memory for the PWM/BCM output path. It stores one `NUM_PWM`-bit word per bit plane, for `PWM_WIDTH` planes. The host writes frames with per-channel masks and commits them. The PWM engine reads a stable bank and switches to the newest committed frame only on `latch_mem`. Double- and triple-buffered modes are supported, and a copy engine carries the committed frame forward so that partial (masked) updates stay coherent.

## Interface
- `PWM_WIDTH`, 16: number of bit planes (memory depth, ≥2); `AW = $clog2(PWM_WIDTH)`.
- `NUM_PWM`, 4: channels (word width, ≥1).
- `NUM_BANKS`, 3: 2 (double buffer) or 3 (triple buffer); any other value is an elaboration error.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `write_enable`  in  1  write `wdata` into write bank at `waddr`, honouring `wmask`.
- `waddr`  in  AW  write plane index.
- `wdata`  in  NUM_PWM  write data.
- `wmask`  in  NUM_PWM  per-channel write enable (1 = update bit).
- `commit`  in  1  single-cycle pulse; write bank becomes a complete frame.
- `wready`  out  1  writer may write/commit; low while copy engine busy.
- `latch_mem`  in  1  frame boundary from PWM engine.
- `raddr`  in  AW  read plane index.
- `rdata`  out  NUM_PWM  registered read data from read bank.
- `pending`  out  1  committed frame awaiting `latch_mem`.
- `swapped`  out  1  one-cycle pulse: read bank changed at this edge.
- `frame_drop`  out  1  one-cycle pulse: a pending frame was replaced before being latched (triple mode only).
- `err`  out  1  sticky: write or commit attempted while `wready`=0; cleared only by `rst`.

## Operation
- Storage: `NUM_BANKS × PWM_WIDTH × NUM_PWM` flop array; contents not reset.
- Bank pointers `rd`, `wr`, and `rdy` (triple only). These are always distinct. Reset: `rd`=0, `wr`=1, `rdy`=2.
- Write: when `write_enable & wready`, `mem[wr][waddr][i] <= wdata[i]` for each `i` with `wmask[i]`=1. Out-of-range `waddr` (≥`PWM_WIDTH`) is ignored.
- Triple mode, with `L` = `latch_mem & pending` and `C` = `commit & wready`:
  - `L & !C`: `rd<=rdy`, `rdy<=rd`, `pending<=0`.
  - `C & !L`: `rdy<=wr`, `wr<=rdy`, `pending<=1`. If `pending` was already 1, pulse `frame_drop`.
  - `L & C`: `rd<=rdy`, `rdy<=wr`, `wr<=rd`, `pending<=1`, no drop.
  - In all `C` cases, `src<=` the newly committed bank and the copy engine starts.
- Double mode:
  - `C`: `pending<=1`.
  - `latch_mem & pending`: swap `rd`/`wr`, `pending<=0`, `src<=` new `rd`, start copy.
  - `commit` while `pending`=1 is a no-op (frame already queued).
- Copy FSM states:
  - IDLE: `wready`=1.
  - COPY: counter `k` runs 0..`PWM_WIDTH-1`, one word per cycle, `mem[wr][k] <= mem[src][k]`, `wready`=0. Return to IDLE after `k=PWM_WIDTH-1`.
  - `src` is never written during COPY. In triple mode a latch during COPY only re-labels `rd`/`rdy` and does not disturb the copy.
- `write_enable` or `commit` while `wready`=0: ignored, `err<=1`. A `latch_mem` during COPY in double mode cannot occur (`pending`=0).
- `latch_mem` with `pending`=0: no state change, no `swapped`.

## Timing
- Read latency 1: `rdata` at edge N+1 = `mem[rd][raddr]` using `rd` and `raddr` from cycle N. In a latch cycle the read uses the pre-swap bank; the next cycle uses the new bank.
- Write in the same cycle as `commit`: the write is included in the committed frame.
- Copy: the commit (or, in double mode, the latch) edge is T. `wready`=0 for cycles T+1 .. T+`PWM_WIDTH`; first accepted write at edge T+`PWM_WIDTH`+1.
- `swapped` and `frame_drop` are high for exactly the cycle after the triggering edge.
- Reset values: `rdata`=0, `wready`=1, `pending`=0, `swapped`=0, `frame_drop`=0, `err`=0, FSM IDLE. Reset mid-COPY aborts the copy immediately, and bank contents are left as-is.

## Test plan
- Triple mode:
  - Stimulus: write planes 0..15 with `wdata`=plane index and `wmask`=4'hF, commit, then `latch_mem`.
  - Required: `pending` is 1 after the commit; `swapped` pulses once; reads return 0..15 from 1 cycle after the latch.
- Masked partial update:
  - Stimulus: after the above, wait for `wready`, write plane 3 with `wdata`=4'hA and `wmask`=4'h1, commit, latch.
  - Required: plane 3 reads 4'h3 before the latch and 4'h2 after it; every other plane is unchanged.
- Double commit without latch:
  - Stimulus: commit frame A, then commit frame B after the copy finishes.
  - Required: `frame_drop` pulses once; the next latch shows frame B; `pending`=0 afterwards.
- Simultaneous events:
  - Stimulus: `latch_mem` and `commit` in the same cycle with `pending`=1.
  - Required: the read bank becomes the old pending frame; `pending` stays 1; no `frame_drop`; `rd`, `rdy`, `wr` remain distinct.
- Busy violation:
  - Stimulus: a write 2 cycles after a commit.
  - Required: the write is ignored, `err`=1 (sticky), and `wready` returns exactly 16 cycles after the commit edge.
- Double mode, `NUM_BANKS`=2, `PWM_WIDTH`=8:
  - Stimulus: `latch_mem` with no commit, then commit followed by latch.
  - Required: the first latch produces no `swapped`; after the second latch, reads show the new frame and `wready` is low for 8 cycles.
  - Also: assert `rst` mid-copy; required: all outputs return to their reset values asynchronously.
